mcr3_dl_ctrl: RTL and testbench
===============================

# mcr3_dl_ctrl

ROM download sequencer for the MCR3 core, clocked on `clk_sys`. It takes the HPS byte stream for index 0 and routes each byte to one of four places: the on-chip CPU ROM, SDRAM port 1, SDRAM port 2, or the background ROM loader. SDRAM writes use the toggle req/ack handshake, and the block stalls the host with `ioctl_wait` until each write is acknowledged. It also owns the core-reset sequencing: hold reset until a load completes, then emit a delayed second reset pulse.

## Interface
- `SND_BASE`, default 25'h0E000: start of the sound ROM region.
- `SP_BASE`, default 25'h12000: start of the sprite ROM region.
- `BG_BASE`, default 25'h32000: start of the background ROM region.
- `ACK_TIMEOUT`, default 8'd200: number of cycles to wait for an SDRAM ack before giving up.
- `RESET_HOLD`, default 16'hFFFF: reload value of the second-reset counter.

Ports (clock and reset first):
- `clk_sys`  in  1  single clock.
- `reset`  in  1  synchronous, active-high system reset.
- `user_reset`  in  1  menu or button reset.
- `ioctl_download`  in  1  download active.
- `ioctl_wr`  in  1  one-cycle byte strobe.
- `ioctl_index`  in  8  download index; only 0 is accepted.
- `ioctl_addr`  in  25  byte address.
- `ioctl_dout`  in  8  byte data.
- `ioctl_wait`  out  1  host stall.
- `cpu_rom_we`  out  1  CPU ROM write strobe.
- `cpu_rom_addr`  out  16  CPU ROM write address.
- `cpu_rom_d`  out  8  CPU ROM write data.
- `p1_req`  out  1  port 1 request toggle.
- `p1_ack`  in  1  port 1 acknowledge toggle.
- `p1_a`  out  23  port 1 word address.
- `p1_ds`  out  2  port 1 byte selects.
- `p1_d`  out  16  port 1 write data.
- `p2_req`  out  1  port 2 request toggle.
- `p2_ack`  in  1  port 2 acknowledge toggle.
- `p2_a`  out  18  port 2 word address.
- `p2_ds`  out  2  port 2 byte selects.
- `p2_d`  out  16  port 2 write data.
- `dl_wr`  out  1  background loader write strobe.
- `dl_addr`  out  25  background loader address.
- `dl_data`  out  8  background loader data.
- `rom_loaded`  out  1  a complete load has finished.
- `core_reset`  out  1  reset to the game core.
- `dl_err`  out  1  sticky error flag (timeout or overrun).

## Operation
- **Accepted byte.** A byte is accepted only when `ioctl_download & ioctl_wr & ioctl_index==0` and the FSM is in IDLE. On acceptance the address and data are latched.
- **Region decode** (A = latched address):
  - MAIN, A < SND_BASE: pulse `cpu_rom_we` with `cpu_rom_addr`=A[15:0], and also issue a port 1 write.
  - SND, SND_BASE ≤ A < SP_BASE: issue a port 1 write only.
  - SPR, SP_BASE ≤ A < BG_BASE: issue a port 2 write with S = A−SP_BASE.
  - BG, A ≥ BG_BASE: pulse `dl_wr` with `dl_addr` = A−BG_BASE. No handshake is needed.
- **Port 1 write fields.** `p1_a`=A[23:1], `p1_ds`={A[0],~A[0]}, `p1_d`={D,D}.
- **Port 2 write fields.** `p2_a`={S[18:17],S[14:0],S[16]}, `p2_ds`={S[15],~S[15]}, `p2_d`={D,D}. This packs the four sprite ROMs into 32-bit words.
- **FSM states:**
  - IDLE:
    - accepted byte in region MAIN/SND/SPR → ISSUE.
    - accepted byte in region BG → IDLE.
  - ISSUE: toggle the selected request line, clear the timeout counter, → WAIT_ACK.
  - WAIT_ACK:
    - `pN_ack == pN_req` → IDLE.
    - timeout counter reaches ACK_TIMEOUT → set `dl_err`, → IDLE. The request is left toggled.
- **ioctl_wait.** High in ISSUE and WAIT_ACK, low in IDLE.
- **Overrun.** A qualifying `ioctl_wr` while not IDLE is dropped and sets `dl_err`. `dl_err` clears only on `reset`.
- **rom_loaded.** Set once the index-0 download has ended (`ioctl_download` falls while index 0) and the FSM is IDLE.
  - If the download ends during WAIT_ACK, the set is deferred until the FSM returns to IDLE.
  - Cleared only by `reset`.
- **Second-reset counter.**
  - Loaded with RESET_HOLD while `user_reset | ~rom_loaded`.
  - Otherwise decrements toward 0 and holds at 0.
- **core_reset** = `reset | user_reset | (ioctl_download & index==0) | ~rom_loaded | (count==1)`, registered.

## Timing
- **Reset values:** all outputs 0, except `core_reset`=1 and count=RESET_HOLD. Request toggles reset to 0, and acks are assumed to reset to 0 as well.
- **BG and CPU ROM strobes** fire exactly one cycle, in the cycle after acceptance.
- **Request toggle** happens 2 cycles after acceptance (cycle +1 is ISSUE).
- **ioctl_wait** goes high in cycle +1. The host may present at most one further strobe in cycle +1; that strobe counts as an overrun.
- **Ack seen in cycle k** → FSM is IDLE and `ioctl_wait` is low in cycle k+1.
- **Reset mid-operation.** `reset` in any state forces IDLE on the next edge, without issuing a pending request.
- **user_reset** does not affect the FSM.
- **Second reset pulse** is exactly one cycle, RESET_HOLD−1 cycles after the count leaves its reload value.

## Structure
- Package `mcr3_dl_pkg` holds:
  - region enum {MAIN, SND, SPR, BG};
  - FSM state enum {IDLE, ISSUE, WAIT_ACK};
  - the default base-address constants.
- Sub-module `mcr3_reset_seq` contains the `rom_loaded` logic, the counter and the `core_reset` generation. The parent supplies a `dl_done` pulse to it.

## Test plan
- **MAIN byte.** Write A=0x01234, D=0xA5.
  - `cpu_rom_we` is 1 for one cycle with addr 0x1234.
  - `p1_req` toggles with `p1_a`=0x091A, `p1_ds`=2'b01, `p1_d`=0xA5A5.
  - `ioctl_wait` drops the cycle after `p1_ack` toggles.
- **SPR byte.** Write A=0x1A001 (S=0x8001).
  - `p2_a`={2'b00,15'h0001,1'b0}=0x00002, `p2_ds`=2'b10.
  - `cpu_rom_we` and `p1_req` stay unchanged.
- **BG byte.** Write A=0x32010.
  - `dl_wr` pulses with `dl_addr`=0x10.
  - `ioctl_wait` stays 0.
- **Timeout and overrun.**
  - Withhold `p1_ack`: after 200 cycles `dl_err`=1 and the FSM returns to IDLE.
  - A strobe during WAIT_ACK also sets `dl_err`.
- **Reset sequence.**
  - End the download while in WAIT_ACK: `rom_loaded` stays 0 until the ack arrives.
  - With RESET_HOLD=16: `core_reset` falls, then re-pulses for exactly 1 cycle 15 cycles later.
  - `user_reset` reloads the counter.
- **Wrong index.** A write with `ioctl_index`=1 produces no strobes, no requests and no `dl_err`.

Source files
------------

// File: rtl/mcr3_dl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mcr3_dl_pkg
// Brief    : Shared types and default ROM map for the MCR3 download sequencer.
// Revision : 1.0
// ============================================================================
package mcr3_dl_pkg;

    typedef enum logic [1:0] {
        MAIN = 2'd0,
        SND  = 2'd1,
        SPR  = 2'd2,
        BG   = 2'd3
    } region_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_ACK = 2'd2
    } dl_state_t;

    localparam logic [24:0] C_SND_BASE = 25'h0E000;
    localparam logic [24:0] C_SP_BASE  = 25'h12000;
    localparam logic [24:0] C_BG_BASE  = 25'h32000;

    function automatic region_t decode_region(
        input logic [24:0] a,
        input logic [24:0] snd_base,
        input logic [24:0] sp_base,
        input logic [24:0] bg_base
    );
        if (a < snd_base)     return MAIN;
        else if (a < sp_base) return SND;
        else if (a < bg_base) return SPR;
        else                  return BG;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mcr3_reset_seq.sv
`default_nettype none
// ============================================================================
// Module   : mcr3_reset_seq
// Brief    : Holds core reset until a ROM load completes, then emits a
//            delayed one-cycle second reset pulse.
// Revision : 1.0
// ============================================================================
module mcr3_reset_seq
    import mcr3_dl_pkg::*;
#(
    parameter logic [15:0] RESET_HOLD = 16'hFFFF
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic user_reset,
    input  logic dl_active,
    input  logic dl_done,
    output logic rom_loaded,
    output logic core_reset
);

    logic [15:0] r_count;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rom_loaded <= 1'b0;
            r_count    <= RESET_HOLD;
            core_reset <= 1'b1;
        end else begin
            if (dl_done)
                rom_loaded <= 1'b1;
            // The counter only runs once a load is in and no user reset is held.
            if (user_reset | ~rom_loaded)
                r_count <= RESET_HOLD;
            else if (r_count != 16'd0)
                r_count <= r_count - 16'd1;
            core_reset <= user_reset | dl_active | ~rom_loaded | (r_count == 16'd1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mcr3_dl_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mcr3_dl_ctrl
// Brief    : Routes HPS index-0 download bytes to CPU ROM, SDRAM ports or the
//            background loader, with toggle handshake and core-reset sequencing.
// Revision : 1.0
// ============================================================================
module mcr3_dl_ctrl
    import mcr3_dl_pkg::*;
#(
    parameter logic [24:0] SND_BASE    = C_SND_BASE,
    parameter logic [24:0] SP_BASE     = C_SP_BASE,
    parameter logic [24:0] BG_BASE     = C_BG_BASE,
    parameter logic [7:0]  ACK_TIMEOUT = 8'd200,
    parameter logic [15:0] RESET_HOLD  = 16'hFFFF
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        user_reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [7:0]  ioctl_index,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic        cpu_rom_we,
    output logic [15:0] cpu_rom_addr,
    output logic [7:0]  cpu_rom_d,
    output logic        p1_req,
    input  logic        p1_ack,
    output logic [22:0] p1_a,
    output logic [1:0]  p1_ds,
    output logic [15:0] p1_d,
    output logic        p2_req,
    input  logic        p2_ack,
    output logic [17:0] p2_a,
    output logic [1:0]  p2_ds,
    output logic [15:0] p2_d,
    output logic        dl_wr,
    output logic [24:0] dl_addr,
    output logic [7:0]  dl_data,
    output logic        rom_loaded,
    output logic        core_reset,
    output logic        dl_err
);

    dl_state_t   r_state, w_state_nxt;
    logic        w_idx0, w_strobe, w_accept, w_ack_match, w_issue, w_timeout;
    logic        r_sel_p2, r_dl_prev, r_done_pend, w_dl_fall, w_dl_done;
    logic [7:0]  r_to_cnt;
    logic [24:0] w_sp_off, w_bg_off;
    region_t     w_region;
    logic        w_unused_bits;

    assign w_idx0      = (ioctl_index == 8'd0);
    assign w_strobe    = ioctl_download & ioctl_wr & w_idx0;
    assign w_accept    = w_strobe & (r_state == IDLE);
    assign w_region    = decode_region(ioctl_addr, SND_BASE, SP_BASE, BG_BASE);
    assign w_sp_off    = ioctl_addr - SP_BASE;
    assign w_bg_off    = ioctl_addr - BG_BASE;
    assign w_ack_match = r_sel_p2 ? (p2_ack == p2_req) : (p1_ack == p1_req);
    assign w_unused_bits = &{1'b0, ioctl_addr[24], w_sp_off[24:19]};

    always_ff @(posedge clk_sys) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:     if (w_accept && (w_region != BG)) w_state_nxt = ISSUE;
            ISSUE:    w_state_nxt = WAIT_ACK;
            WAIT_ACK: if (w_ack_match || (r_to_cnt == ACK_TIMEOUT)) w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ioctl_wait = (r_state != IDLE);
        w_issue    = (r_state == ISSUE);
        w_timeout  = (r_state == WAIT_ACK) && !w_ack_match && (r_to_cnt == ACK_TIMEOUT);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cpu_rom_we   <= 1'b0;
            cpu_rom_addr <= '0;
            cpu_rom_d    <= '0;
            p1_req       <= 1'b0;
            p1_a         <= '0;
            p1_ds        <= '0;
            p1_d         <= '0;
            p2_req       <= 1'b0;
            p2_a         <= '0;
            p2_ds        <= '0;
            p2_d         <= '0;
            dl_wr        <= 1'b0;
            dl_addr      <= '0;
            dl_data      <= '0;
            dl_err       <= 1'b0;
            r_sel_p2     <= 1'b0;
            r_to_cnt     <= '0;
        end else begin
            cpu_rom_we <= w_accept && (w_region == MAIN);
            dl_wr      <= w_accept && (w_region == BG);
            if (w_accept) begin
                if (w_region == MAIN) begin
                    cpu_rom_addr <= ioctl_addr[15:0];
                    cpu_rom_d    <= ioctl_dout;
                end
                if (w_region == MAIN || w_region == SND) begin
                    r_sel_p2 <= 1'b0;
                    p1_a     <= ioctl_addr[23:1];
                    p1_ds    <= {ioctl_addr[0], ~ioctl_addr[0]};
                    p1_d     <= {ioctl_dout, ioctl_dout};
                end
                // Four sprite ROMs interleave into 32-bit words: S[16] picks the
                // half-word, S[15] the byte lane.
                if (w_region == SPR) begin
                    r_sel_p2 <= 1'b1;
                    p2_a     <= {w_sp_off[18:17], w_sp_off[14:0], w_sp_off[16]};
                    p2_ds    <= {w_sp_off[15], ~w_sp_off[15]};
                    p2_d     <= {ioctl_dout, ioctl_dout};
                end
                if (w_region == BG) begin
                    dl_addr <= w_bg_off;
                    dl_data <= ioctl_dout;
                end
            end
            if (w_issue) begin
                r_to_cnt <= '0;
                if (r_sel_p2) p2_req <= ~p2_req;
                else          p1_req <= ~p1_req;
            end else if (r_state == WAIT_ACK) begin
                r_to_cnt <= r_to_cnt + 8'd1;
            end
            dl_err <= dl_err | w_timeout | (w_strobe & (r_state != IDLE));
        end
    end

    // A download that ends mid-handshake only counts once the FSM is idle.
    assign w_dl_fall = r_dl_prev & ~ioctl_download;
    assign w_dl_done = (r_done_pend | w_dl_fall) & (r_state == IDLE);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_dl_prev   <= 1'b0;
            r_done_pend <= 1'b0;
        end else begin
            r_dl_prev   <= ioctl_download & w_idx0;
            r_done_pend <= (r_done_pend | w_dl_fall) & (r_state != IDLE);
        end
    end

    mcr3_reset_seq #(
        .RESET_HOLD (RESET_HOLD)
    ) u_reset_seq (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .user_reset (user_reset),
        .dl_active  (ioctl_download & w_idx0),
        .dl_done    (w_dl_done),
        .rom_loaded (rom_loaded),
        .core_reset (core_reset)
    );

endmodule
`default_nettype wire

// File: tb/tb_mcr3_dl_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mcr3_dl_ctrl
// Brief    : Self-checking bench for mcr3_dl_ctrl against a transaction model.
// Revision : 1.0
// ============================================================================
module tb_mcr3_dl_ctrl;

    localparam int c_snd = 32'h0E000;
    localparam int c_sp  = 32'h12000;
    localparam int c_bg  = 32'h32000;

    logic        clk_sys = 1'b0;
    logic        reset, user_reset, ioctl_download, ioctl_wr;
    logic [7:0]  ioctl_index, ioctl_dout;
    logic [24:0] ioctl_addr;
    logic        ioctl_wait, cpu_rom_we, p1_req, p1_ack, p2_req, p2_ack;
    logic [15:0] cpu_rom_addr, p1_d, p2_d;
    logic [7:0]  cpu_rom_d, dl_data;
    logic [22:0] p1_a;
    logic [17:0] p2_a;
    logic [1:0]  p1_ds, p2_ds;
    logic        dl_wr, rom_loaded, core_reset, dl_err;
    logic [24:0] dl_addr;

    int n_checks = 0;
    int n_fail   = 0;
    logic exp_p1 = 1'b0;
    logic exp_p2 = 1'b0;

    always #5 clk_sys = ~clk_sys;

    mcr3_dl_ctrl #(.RESET_HOLD(16'd16)) dut (
        .clk_sys(clk_sys), .reset(reset), .user_reset(user_reset),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
        .cpu_rom_we(cpu_rom_we), .cpu_rom_addr(cpu_rom_addr), .cpu_rom_d(cpu_rom_d),
        .p1_req(p1_req), .p1_ack(p1_ack), .p1_a(p1_a), .p1_ds(p1_ds), .p1_d(p1_d),
        .p2_req(p2_req), .p2_ack(p2_ack), .p2_a(p2_a), .p2_ds(p2_ds), .p2_d(p2_d),
        .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
        .rom_loaded(rom_loaded), .core_reset(core_reset), .dl_err(dl_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // One byte transaction; dly < 0 leaves the handshake open in WAIT_ACK.
    task automatic send(input int a, input int d, input int dly);
        int rg, s;
        rg = (a < c_snd) ? 0 : (a < c_sp) ? 1 : (a < c_bg) ? 2 : 3;
        ioctl_addr = a[24:0];
        ioctl_dout = d[7:0];
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
        chk("cpu_we_pulse", cpu_rom_we, rg == 0);
        if (rg == 0) begin
            chk("cpu_addr", cpu_rom_addr, a % 65536);
            chk("cpu_d", cpu_rom_d, d);
        end
        chk("dl_wr_pulse", dl_wr, rg == 3);
        if (rg == 3) begin
            chk("dl_addr", dl_addr, a - c_bg);
            chk("dl_data", dl_data, d);
        end
        chk("wait_rise", ioctl_wait, rg != 3);
        if (rg <= 1) exp_p1 = ~exp_p1;
        if (rg == 2) exp_p2 = ~exp_p2;
        tick();
        chk("cpu_we_once", cpu_rom_we, 0);
        chk("dl_wr_once", dl_wr, 0);
        chk("p1_req", p1_req, exp_p1);
        chk("p2_req", p2_req, exp_p2);
        if (rg <= 1) begin
            chk("p1_a", p1_a, (a / 2) % (1 << 23));
            chk("p1_ds", p1_ds, (a % 2) ? 2 : 1);
            chk("p1_d", p1_d, d * 257);
        end
        if (rg == 2) begin
            s = a - c_sp;
            chk("p2_a", p2_a, ((s / 131072) % 4) * 65536 + (s % 32768) * 2 + (s / 65536) % 2);
            chk("p2_ds", p2_ds, ((s / 32768) % 2) ? 2 : 1);
            chk("p2_d", p2_d, d * 257);
        end
        if (rg == 3) begin
            chk("wait_bg", ioctl_wait, 0);
            return;
        end
        if (dly < 0) return;
        for (int i = 0; i < dly; i++) begin
            chk("wait_hold", ioctl_wait, 1);
            tick();
        end
        if (rg <= 1) p1_ack = exp_p1;
        else         p2_ack = exp_p2;
        tick();
        chk("wait_drop", ioctl_wait, 0);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        p1_ack = 1'b0;
        p2_ack = 1'b0;
        exp_p1 = 1'b0;
        exp_p2 = 1'b0;
        tick();
        reset  = 1'b0;
    endtask

    initial begin
        int n, a, rg;
        user_reset = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
        ioctl_index = 8'd0; ioctl_addr = '0; ioctl_dout = '0;
        reset = 1'b1; p1_ack = 1'b0; p2_ack = 1'b0;
        repeat (3) tick();
        chk("rst_cpu_we", cpu_rom_we, 0);
        chk("rst_p1_req", p1_req, 0);
        chk("rst_p2_req", p2_req, 0);
        chk("rst_wait", ioctl_wait, 0);
        chk("rst_err", dl_err, 0);
        chk("rst_loaded", rom_loaded, 0);
        chk("rst_core_reset", core_reset, 1);
        reset = 1'b0;
        ioctl_download = 1'b1;
        tick();

        send(32'h01234, 8'hA5, 3);
        send(32'h1A001, 8'h3C, 2);
        send(32'h32010, 8'h77, 0);

        ioctl_index = 8'd1;
        ioctl_addr  = 25'h01000;
        ioctl_wr    = 1'b1;
        tick();
        ioctl_wr    = 1'b0;
        ioctl_index = 8'd0;
        chk("idx1_cpu_we", cpu_rom_we, 0);
        chk("idx1_dl_wr", dl_wr, 0);
        chk("idx1_wait", ioctl_wait, 0);
        tick();
        chk("idx1_p1_req", p1_req, exp_p1);
        chk("idx1_p2_req", p2_req, exp_p2);
        chk("idx1_err", dl_err, 0);

        for (int k = 0; k < 40; k++) begin
            rg = $urandom_range(0, 3);
            case (rg)
                0:       a = $urandom_range(0, c_snd - 1);
                1:       a = $urandom_range(c_snd, c_sp - 1);
                2:       a = $urandom_range(c_sp, c_bg - 1);
                default: a = $urandom_range(c_bg, c_bg + 32'hFFFFF);
            endcase
            send(a, $urandom_range(0, 255), $urandom_range(0, 5));
        end
        chk("rand_err", dl_err, 0);

        // Download ends while a port 1 write is still waiting for its ack.
        send(32'h00100, 8'h11, -1);
        ioctl_download = 1'b0;
        repeat (3) tick();
        chk("loaded_deferred", rom_loaded, 0);
        p1_ack = exp_p1;
        n = 0;
        while (!rom_loaded && n < 10) begin tick(); n++; end
        chk("loaded_set", rom_loaded, 1);
        n = 0;
        while (core_reset && n < 10) begin tick(); n++; end
        chk("core_reset_fall", core_reset, 0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk("second_pulse", core_reset, i == 15);
        end
        user_reset = 1'b1;
        tick();
        user_reset = 1'b0;
        chk("user_reset_core", core_reset, 1);
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk("user_reload_pulse", core_reset, i == 16);
        end

        // Overrun: a second strobe while the handshake is outstanding.
        ioctl_download = 1'b1;
        tick();
        send(32'h00200, 8'h22, -1);
        ioctl_addr = 25'h00300;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
        chk("overrun_err", dl_err, 1);
        chk("overrun_dropped", cpu_rom_we, 0);
        p1_ack = exp_p1;
        tick();
        chk("overrun_wait_drop", ioctl_wait, 0);
        chk("overrun_p1_req", p1_req, exp_p1);

        // Reset while ISSUE is pending must not toggle the request.
        do_reset();
        ioctl_addr = 25'h00400;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
        do_reset();
        chk("midrst_wait", ioctl_wait, 0);
        chk("midrst_p1_req", p1_req, 0);
        chk("midrst_err", dl_err, 0);
        tick();
        chk("midrst_p1_req2", p1_req, 0);

        // Timeout with ack withheld.
        send(32'h00500, 8'h33, -1);
        n = 0;
        while (ioctl_wait && n < 300) begin
            if (n == 148) chk("timeout_early_err", dl_err, 0);
            tick();
            n++;
        end
        chk("timeout_window", (n + 2 >= 200) && (n + 2 <= 205), 1);
        chk("timeout_err", dl_err, 1);
        chk("timeout_req_left", p1_req, exp_p1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
